// File: rtl/spi_receiver.sv
// spi_receiver: SPI peripheral-side receiver (mode 0, CS active-low, MSB first).
// Synchronises sclk/mosi/cs into the clock_in domain, deserialises each frame into a
// right-aligned word and flags short, over-long and bad-length frames.
//
// Ports:
//   clock_in        system clock, all logic on posedge
//   reset_in        asynchronous active-high reset
//   sclk_in         SPI clock from master (async)
//   mosi_in         SPI data from master (async)
//   cs_in           SPI chip select, active low (async)
//   data_length_in  expected bits per frame, sampled when cs falls
//   data_out        last good word, right-aligned, upper bits zero
//   data_valid_out  one-cycle pulse when data_out updates
//   busy_out        high while a frame is in progress
//   frame_error_out one-cycle pulse on an aborted or bad frame
module spi_receiver #(
  parameter int unsigned MAX_BITS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clock_in,
  input  logic                reset_in,
  input  logic                sclk_in,
  input  logic                mosi_in,
  input  logic                cs_in,
  input  logic [5:0]          data_length_in,
  output logic [MAX_BITS-1:0] data_out,
  output logic                data_valid_out,
  output logic                busy_out,
  output logic                frame_error_out
);

  localparam int unsigned LEN_W = 6;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  // Input synchronisers and edge history, reset to the idle pin levels
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_prev;
  logic                   cs_prev;
  logic [SYNC_STAGES:0]   fill_sr;
  logic                   armed_q;

  logic sclk_s;
  logic mosi_s;
  logic cs_s;
  logic sclk_rise;
  logic cs_fall;
  logic cs_rise;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      fill_sr   <= '0;
      armed_q   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_in};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      fill_sr   <= {fill_sr[SYNC_STAGES-1:0], 1'b1};
      // Only accept a cs fall once cs has really been seen high after reset,
      // so a frame already in progress at reset release is ignored.
      if (fill_sr[SYNC_STAGES] && cs_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;

  // Frame state and registered outputs
  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [MAX_BITS-1:0] shift_q, shift_d;
  logic                bad_len_q, bad_len_d;
  logic                overrun_q, overrun_d;
  logic [MAX_BITS-1:0] data_d;
  logic                valid_d;
  logic                busy_d;
  logic                error_d;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q         <= IDLE;
      len_q           <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      bad_len_q       <= 1'b0;
      overrun_q       <= 1'b0;
      data_out        <= '0;
      data_valid_out  <= 1'b0;
      busy_out        <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      bad_len_q       <= bad_len_d;
      overrun_q       <= overrun_d;
      data_out        <= data_d;
      data_valid_out  <= valid_d;
      busy_out        <= busy_d;
      frame_error_out <= error_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    bad_len_d = bad_len_q;
    overrun_d = overrun_q;
    data_d    = data_out;
    valid_d   = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A simultaneous sclk rise only opens the frame; it is not sampled.
        if (cs_fall && armed_q) begin
          len_d     = data_length_in;
          bit_cnt_d = '0;
          shift_d   = '0;
          overrun_d = 1'b0;
          if (data_length_in == '0 || data_length_in > MAX_LEN) begin
            bad_len_d = 1'b1;
            error_d   = 1'b1;
            state_d   = WAIT_CS;
          end else begin
            bad_len_d = 1'b0;
            state_d   = RECEIVE;
          end
        end
      end

      RECEIVE: begin
        if (sclk_rise) begin
          shift_d   = {shift_q[MAX_BITS-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + LEN_W'(1);
          if (bit_cnt_d == len_q) begin
            // Final bit beats a coincident cs rise: deliver and finish the frame.
            data_d  = shift_d;
            valid_d = 1'b1;
            state_d = cs_rise ? IDLE : WAIT_CS;
          end else if (cs_rise) begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end else if (cs_rise) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end

      WAIT_CS: begin
        if (sclk_rise) begin
          overrun_d = 1'b1;
        end
        if (cs_rise) begin
          // A bad length was already reported when the frame opened.
          error_d = overrun_d && !bad_len_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_spi_receiver.sv
// tb_spi_receiver: self-checking bench for spi_receiver. Drives SPI frames at pin level,
// counts valid/error pulses with a monitor and compares each frame against expectations
// from a table and from a frame-level reference model for randomized frames.
module tb_spi_receiver;

  logic        clk;
  logic        rst;
  logic        sclk;
  logic        mosi;
  logic        cs;
  logic [5:0]  data_length;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        frame_error;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_err = 0;

  spi_receiver #(.MAX_BITS(16), .SYNC_STAGES(2)) dut (
    .clock_in        (clk),
    .reset_in        (rst),
    .sclk_in         (sclk),
    .mosi_in         (mosi),
    .cs_in           (cs),
    .data_length_in  (data_length),
    .data_out        (data_out),
    .data_valid_out  (data_valid),
    .busy_out        (busy),
    .frame_error_out (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Pulse counters and the valid/error exclusivity check, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) n_valid++;
      if (frame_error) n_err++;
      check("valid_and_error_same_cycle", int'(data_valid & frame_error), 0);
    end
  end

  task automatic wait_clks(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: what a frame of n clocked bits should produce
  function automatic void model(input int len, input logic [31:0] stream, input int n,
                                input logic [15:0] last, output int v, output int em,
                                output int ee, output logic [15:0] data);
    data = last;
    v = 0; em = 0; ee = 0;
    if (len == 0 || len > 16) begin
      em = 1;
    end else if (n >= len) begin
      v = 1;
      data = 16'(stream >> (32 - len));
      ee = (n > len) ? 1 : 0;
    end else begin
      ee = 1;
    end
  endfunction

  // Drive one frame: optional junk sclk rise coincident with cs fall, optional
  // final sclk rise coincident with cs rise.
  task automatic send_frame(input int len, input logic [31:0] stream, input int n,
                            input bit coinc_start, input bit coinc_end,
                            output int v_mid, output int e_mid, output int busy_mid,
                            output int v_tot, output int e_tot, output int busy_end);
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_err;
    v_mid = 0; e_mid = 0; busy_mid = 0;
    data_length = 6'(len);
    if (coinc_start) begin
      mosi = 1'b1;
      cs = 1'b0;
      sclk = 1'b1;
      wait_clks(5);
      sclk = 1'b0;
      wait_clks(5);
    end else begin
      cs = 1'b0;
      wait_clks(5);
    end
    // Length must only be taken when cs falls.
    data_length = 6'($urandom_range(0, 63));
    for (int i = 0; i < n; i++) begin
      mosi = stream[31 - i];
      wait_clks(5);
      if (coinc_end && i == n - 1) begin
        v_mid = n_valid - v0;
        e_mid = n_err - e0;
        busy_mid = int'(busy);
        sclk = 1'b1;
        cs = 1'b1;
        wait_clks(5);
        sclk = 1'b0;
      end else begin
        sclk = 1'b1;
        wait_clks(5);
        sclk = 1'b0;
      end
    end
    if (!coinc_end) begin
      wait_clks(5);
      v_mid = n_valid - v0;
      e_mid = n_err - e0;
      busy_mid = int'(busy);
      cs = 1'b1;
    end
    wait_clks(6);
    v_tot = n_valid - v0;
    e_tot = n_err - e0;
    busy_end = int'(busy);
  endtask

  typedef struct {
    int          len;
    logic [31:0] stream;
    int          nrise;
    int          exp_v;
    int          exp_em;
    int          exp_ee;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic run_and_check(input string tag, input int len, input logic [31:0] stream,
                               input int n, input int ev, input int eem, input int eee,
                               input logic [15:0] edata);
    int v_mid, e_mid, busy_mid, v_tot, e_tot, busy_end;
    send_frame(len, stream, n, 1'b0, 1'b0, v_mid, e_mid, busy_mid, v_tot, e_tot, busy_end);
    check({tag, " valid_before_cs_rise"}, v_mid, ev);
    check({tag, " error_before_cs_rise"}, e_mid, eem);
    check({tag, " busy_mid_frame"}, busy_mid, 1);
    check({tag, " valid_total"}, v_tot, ev);
    check({tag, " error_total"}, e_tot, eem + eee);
    check({tag, " data_out"}, int'(data_out), int'(edata));
    check({tag, " busy_after_cs_rise"}, busy_end, 0);
  endtask

  initial begin
    logic [15:0] exp_data;
    int v_mid, e_mid, busy_mid, v_tot, e_tot, busy_end;
    int v0, e0;
    logic [15:0] word;

    vecs[0] = '{16, 32'hA5C3_0000, 16, 1, 0, 0, 16'hA5C3};
    vecs[1] = '{8,  32'h3C00_0000, 8,  1, 0, 0, 16'h003C};
    vecs[2] = '{8,  32'hFF00_0000, 5,  0, 0, 1, 16'h003C};
    vecs[3] = '{8,  32'h9A40_0000, 10, 1, 0, 1, 16'h009A};
    vecs[4] = '{0,  32'hFFFF_0000, 3,  0, 1, 0, 16'h009A};
    vecs[5] = '{17, 32'h5555_0000, 0,  0, 1, 0, 16'h009A};
    vecs[6] = '{1,  32'h8000_0000, 1,  1, 0, 0, 16'h0001};
    vecs[7] = '{12, 32'hABC0_0000, 12, 1, 0, 0, 16'h0ABC};
    vecs[8] = '{8,  32'hFFFF_FFFF, 0,  0, 0, 1, 16'h0ABC};

    rst = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    cs = 1'b1;
    data_length = 6'd0;
    wait_clks(3);
    check("reset data_out", int'(data_out), 0);
    check("reset data_valid", int'(data_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset frame_error", int'(frame_error), 0);
    rst = 1'b0;
    wait_clks(8);
    check("post_reset busy", int'(busy), 0);
    check("post_reset no_pulses", n_valid + n_err, 0);

    // Table of directed frames
    for (int i = 0; i < 9; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].len, vecs[i].stream, vecs[i].nrise,
                    vecs[i].exp_v, vecs[i].exp_em, vecs[i].exp_ee, vecs[i].exp_data);
    end
    exp_data = vecs[8].exp_data;

    // Randomized frames against the reference model
    for (int i = 0; i < 24; i++) begin
      int len, n, ev, eem, eee;
      logic [31:0] stream;
      logic [15:0] nd;
      if ($urandom_range(0, 7) == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : 17 + int'($urandom_range(0, 46));
        n = int'($urandom_range(0, 3));
      end else begin
        len = int'($urandom_range(1, 16));
        n = int'($urandom_range(0, len + 3));
      end
      stream = $urandom;
      model(len, stream, n, exp_data, ev, eem, eee, nd);
      run_and_check($sformatf("rnd%0d len=%0d n=%0d", i, len, n), len, stream, n,
                    ev, eem, eee, nd);
      exp_data = nd;
    end

    // cs fall and sclk rise together: that edge is not sampled
    send_frame(8, 32'h5A00_0000, 8, 1'b1, 1'b0, v_mid, e_mid, busy_mid, v_tot, e_tot, busy_end);
    check("coinc_start valid_total", v_tot, 1);
    check("coinc_start error_total", e_tot, 0);
    check("coinc_start data_out", int'(data_out), 16'h005A);
    check("coinc_start busy_end", busy_end, 0);

    // cs rise with the final sclk rise: word delivered, back to idle
    send_frame(8, 32'hC300_0000, 8, 1'b0, 1'b1, v_mid, e_mid, busy_mid, v_tot, e_tot, busy_end);
    check("coinc_end valid_before_last", v_mid, 0);
    check("coinc_end busy_before_last", busy_mid, 1);
    check("coinc_end valid_total", v_tot, 1);
    check("coinc_end error_total", e_tot, 0);
    check("coinc_end data_out", int'(data_out), 16'h00C3);
    check("coinc_end busy_end", busy_end, 0);

    // Reset in the middle of a frame
    word = 16'hF0F0;
    cs = 1'b0;
    wait_clks(5);
    for (int i = 0; i < 4; i++) begin
      mosi = word[15 - i];
      wait_clks(5);
      sclk = 1'b1;
      wait_clks(5);
      sclk = 1'b0;
    end
    check("mid_frame busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_reset data_out", int'(data_out), 0);
    check("mid_reset busy", int'(busy), 0);
    check("mid_reset data_valid", int'(data_valid), 0);
    check("mid_reset frame_error", int'(frame_error), 0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(8);
    v0 = n_valid;
    e0 = n_err;
    for (int i = 0; i < 2; i++) begin
      mosi = 1'b1;
      wait_clks(5);
      sclk = 1'b1;
      wait_clks(5);
      sclk = 1'b0;
    end
    wait_clks(3);
    check("stale_frame busy", int'(busy), 0);
    check("stale_frame pulses", (n_valid - v0) + (n_err - e0), 0);
    check("stale_frame data_out", int'(data_out), 0);
    cs = 1'b1;
    wait_clks(4);
    run_and_check("after_reset", 16, 32'h1234_0000, 16, 1, 0, 0, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
